// File: rtl/cache_port_arbiter.sv
// Two-requester round-robin arbiter for the cache read port, with per-requester access/hit counters
// and a serial divider reporting hit rate. Access: 2 cycles minimum req-to-done; divide: CNT_W+7 cycles.
// Backpressure: requesters hold req/addr until done; the cache stalls an access by holding cache_ready low.
module cache_port_arbiter #(
   parameter int ADDR_W = 15,
   parameter int CNT_W  = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic              done0,
   output logic              done1,
   output logic              hit0,
   output logic              hit1,
   output logic              cache_read,
   output logic [ADDR_W-1:0] cache_addr,
   input  logic              cache_ready,
   input  logic              cache_hit,
   input  logic              stat_start,
   input  logic              stat_sel,
   output logic              stat_busy,
   output logic              stat_valid,
   output logic [6:0]        hit_rate,
   output logic [CNT_W-1:0]  acc_cnt0,
   output logic [CNT_W-1:0]  acc_cnt1,
   output logic [CNT_W-1:0]  hit_cnt0,
   output logic [CNT_W-1:0]  hit_cnt1
);

   localparam int NUM_W = CNT_W + 7;
   localparam int BC_W  = $clog2(NUM_W);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [NUM_W-1:0] HUNDRED   = NUM_W'(100);
   localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(NUM_W - 1);

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
   typedef enum logic {DIV_IDLE, DIV_RUN}  div_state_t;

   // arbiter state
   arb_state_t        arb_state_q;
   logic              win_q;        // requester owning the current access
   logic              last_q;       // requester served most recently
   logic              cache_read_q;
   logic [ADDR_W-1:0] cache_addr_q;
   logic              done0_q, done1_q, hit0_q, hit1_q;
   logic [CNT_W-1:0]  acc_cnt0_q, acc_cnt1_q, hit_cnt0_q, hit_cnt1_q;
   logic [CNT_W-1:0]  acc_cnt0_d, acc_cnt1_d, hit_cnt0_d, hit_cnt1_d;
   logic              grant_sel;
   logic              complete;

   // divider state
   div_state_t        div_state_q;
   logic [NUM_W-1:0]  num_q;        // dividend shifting out, quotient shifting in
   logic [CNT_W-1:0]  rem_q;
   logic [CNT_W-1:0]  den_q;
   logic [BC_W-1:0]   bit_cnt_q;
   logic [6:0]        rate_q;
   logic              stat_valid_q, stat_busy_q;
   logic [CNT_W:0]    rem_shift;
   logic [CNT_W-1:0]  rem_sub, rem_next;
   logic              rem_ge;
   logic [NUM_W-1:0]  num_next, num_init;
   logic [CNT_W-1:0]  sel_acc, sel_hit;

   // Winner selection: contention goes to whoever was not served last.
   always_comb begin
      grant_sel = 1'b0;
      if (req0 && req1) grant_sel = ~last_q;
      else if (req1)    grant_sel = 1'b1;
      complete = (arb_state_q == ARB_BUSY) && cache_ready;
   end

   // Counter update on completion; a saturated access count freezes both counters of that requester.
   always_comb begin
      acc_cnt0_d = acc_cnt0_q;
      acc_cnt1_d = acc_cnt1_q;
      hit_cnt0_d = hit_cnt0_q;
      hit_cnt1_d = hit_cnt1_q;
      if (complete && !win_q && acc_cnt0_q != CNT_MAX) begin
         acc_cnt0_d = acc_cnt0_q + 1'b1;
         hit_cnt0_d = hit_cnt0_q + {{(CNT_W-1){1'b0}}, cache_hit};
      end
      if (complete && win_q && acc_cnt1_q != CNT_MAX) begin
         acc_cnt1_d = acc_cnt1_q + 1'b1;
         hit_cnt1_d = hit_cnt1_q + {{(CNT_W-1){1'b0}}, cache_hit};
      end
   end

   // Arbiter FSM: one outstanding cache read, done/hit registered toward the winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arb_state_q  <= ARB_IDLE;
         win_q        <= 1'b0;
         last_q       <= 1'b1;
         cache_read_q <= 1'b0;
         cache_addr_q <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         hit0_q       <= 1'b0;
         hit1_q       <= 1'b0;
         acc_cnt0_q   <= '0;
         acc_cnt1_q   <= '0;
         hit_cnt0_q   <= '0;
         hit_cnt1_q   <= '0;
      end else begin
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         acc_cnt0_q <= acc_cnt0_d;
         acc_cnt1_q <= acc_cnt1_d;
         hit_cnt0_q <= hit_cnt0_d;
         hit_cnt1_q <= hit_cnt1_d;
         case (arb_state_q)
            ARB_IDLE: begin
               if (req0 || req1) begin
                  win_q        <= grant_sel;
                  cache_addr_q <= grant_sel ? addr1 : addr0;
                  cache_read_q <= 1'b1;
                  arb_state_q  <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (cache_ready) begin
                  cache_read_q <= 1'b0;
                  if (win_q) begin
                     done1_q <= 1'b1;
                     hit1_q  <= cache_hit;
                  end else begin
                     done0_q <= 1'b1;
                     hit0_q  <= cache_hit;
                  end
                  last_q      <= win_q;
                  arb_state_q <= ARB_IDLE;
               end
            end
            default: arb_state_q <= ARB_IDLE;
         endcase
      end
   end

   // Restoring divider step and snapshot operands.
   always_comb begin
      sel_acc   = stat_sel ? acc_cnt1_q : acc_cnt0_q;
      sel_hit   = stat_sel ? hit_cnt1_q : hit_cnt0_q;
      num_init  = {7'd0, sel_hit} * HUNDRED;
      rem_shift = {rem_q, num_q[NUM_W-1]};
      rem_ge    = rem_shift >= {1'b0, den_q};
      rem_sub   = rem_shift[CNT_W-1:0] - den_q;
      rem_next  = rem_ge ? rem_sub : rem_shift[CNT_W-1:0];
      num_next  = {num_q[NUM_W-2:0], rem_ge};
   end

   // Divider FSM: snapshot on start, one quotient bit per cycle, zero denominator short-cuts to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_state_q  <= DIV_IDLE;
         num_q        <= '0;
         rem_q        <= '0;
         den_q        <= '0;
         bit_cnt_q    <= '0;
         rate_q       <= '0;
         stat_valid_q <= 1'b0;
         stat_busy_q  <= 1'b0;
      end else begin
         stat_valid_q <= 1'b0;
         case (div_state_q)
            DIV_IDLE: begin
               if (stat_start) begin
                  if (sel_acc == '0) begin
                     rate_q       <= '0;
                     stat_valid_q <= 1'b1;
                  end else begin
                     num_q       <= num_init;
                     rem_q       <= '0;
                     den_q       <= sel_acc;
                     bit_cnt_q   <= '0;
                     stat_busy_q <= 1'b1;
                     div_state_q <= DIV_RUN;
                  end
               end
            end
            DIV_RUN: begin
               num_q     <= num_next;
               rem_q     <= rem_next;
               bit_cnt_q <= bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  rate_q       <= num_next[6:0];
                  stat_valid_q <= 1'b1;
                  stat_busy_q  <= 1'b0;
                  div_state_q  <= DIV_IDLE;
               end
            end
            default: div_state_q <= DIV_IDLE;
         endcase
      end
   end

   assign done0      = done0_q;
   assign done1      = done1_q;
   assign hit0       = hit0_q;
   assign hit1       = hit1_q;
   assign cache_read = cache_read_q;
   assign cache_addr = cache_addr_q;
   assign stat_busy  = stat_busy_q;
   assign stat_valid = stat_valid_q;
   assign hit_rate   = rate_q;
   assign acc_cnt0   = acc_cnt0_q;
   assign acc_cnt1   = acc_cnt1_q;
   assign hit_cnt0   = hit_cnt0_q;
   assign hit_cnt1   = hit_cnt1_q;

endmodule
